mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 56 +++++
 rtl/mc_ctrl_alu_dec.sv | 57 +++++
 rtl/mc_ctrl.sv | 155 +++++++++++++++
 tb/tb_mc_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller.
// Holds FSM state encodings, opcode/funct constants, ALU operation codes
// and the PC-source / ALU B-operand mux select codes.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExecR  = 4'd2,
    StExecI  = 4'd3,
    StMemAdr = 4'd4,
    StMemRd  = 4'd5,
    StMemWb  = 4'd6,
    StMemWr  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAluWb  = 4'd10
  } state_e;

  // Opcodes, instruction[31:26]
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes, instruction[5:0]
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnSlt  = 6'b101010;

  // ALU operations
  localparam logic [2:0] AluAdd    = 3'b000;
  localparam logic [2:0] AluSub    = 3'b001;
  localparam logic [2:0] AluOr     = 3'b010;
  localparam logic [2:0] AluSlt    = 3'b011;
  localparam logic [2:0] AluAddOvf = 3'b100;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] AluBRt    = 2'b00;
  localparam logic [1:0] AluBFour  = 2'b01;
  localparam logic [1:0] AluBImm   = 2'b10;
  localparam logic [1:0] AluBImmSh = 2'b11;

  function automatic logic funct_supported(logic [5:0] f);
    return (f == FnAddu) || (f == FnSubu) || (f == FnSlt);
  endfunction

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// ALU control decoder.
// Maps the current FSM state and the latched op/funct to the ALU operation
// and the immediate extension mode.
//   state   in  current FSM state
//   op_q    in  latched opcode
//   funct_q in  latched funct field
//   aluctr  out ALU operation code
//   ext_op  out 1 sign-extend, 0 zero-extend imm16
module alu_dec
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op_q,
  input  logic [5:0] funct_q,
  output logic [2:0] aluctr,
  output logic       ext_op
);

  always_comb begin
    aluctr = AluAdd;
    ext_op = 1'b0;
    case (state)
      StFetch: aluctr = AluAdd;
      // Branch target precompute: PC + (sext(imm16) << 2)
      StDecode: begin
        aluctr = AluAdd;
        ext_op = 1'b1;
      end
      StExecR: begin
        case (funct_q)
          FnSubu:  aluctr = AluSub;
          FnSlt:   aluctr = AluSlt;
          default: aluctr = AluAdd;
        endcase
      end
      StExecI: begin
        if (op_q == OpOri) begin
          aluctr = AluOr;
          ext_op = 1'b0;
        end else begin
          aluctr = AluAddOvf;
          ext_op = 1'b1;
        end
      end
      StMemAdr: begin
        aluctr = AluAdd;
        ext_op = 1'b1;
      end
      StBranch: aluctr = AluSub;
      default: begin
        aluctr = AluAdd;
        ext_op = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle controller for a MIPS subset (addu/subu/slt/ori/addi/lw/sw/beq/j).
// Moore FSM: all datapath controls decode from the state register and the
// op/funct latched in DECODE. Only pc_wr in BRANCH (zero) and the addi
// overflow capture look at ALU flags.
//   clk, rst_n         clock, async active-low reset
//   op, funct          instruction[31:26], instruction[5:0]
//   zero, overflow     ALU flags
//   pc_wr, pc_src      PC write enable and source select
//   ir_wr              instruction register write
//   mem_wr, mem_to_reg data memory write, register data from memory
//   reg_wr, reg_dst    register file write, write address rd(1)/rt(0)
//   alu_src_a/_b       ALU operand selects
//   ext_op, aluctr     immediate extension, ALU operation
//   ovf_wr, ovf_val    write latched addi overflow into $30[0]
//   state              current state, for debug
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       mem_wr,
  output logic       mem_to_reg,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] aluctr,
  output logic       ovf_wr,
  output logic       ovf_val,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic       ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= 6'd0;
      funct_q <= 6'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d    = StFetch;
    op_d       = op_q;
    funct_d    = funct_q;
    ovf_d      = ovf_q;
    pc_wr      = 1'b0;
    pc_src     = PcSrcAlu;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = AluBRt;
    ovf_wr     = 1'b0;
    case (state_q)
      StFetch: begin
        ir_wr     = 1'b1;
        pc_wr     = 1'b1;
        alu_src_b = AluBFour;
        state_d   = StDecode;
      end
      StDecode: begin
        alu_src_b = AluBImmSh;
        op_d      = op;
        funct_d   = funct;
        // Dispatch on the live IR fields; op_q is not valid until next cycle.
        case (op)
          OpRType:      state_d = funct_supported(funct) ? StExecR : StFetch;
          OpOri, OpAddi: state_d = StExecI;
          OpLw, OpSw:   state_d = StMemAdr;
          OpBeq:        state_d = StBranch;
          OpJ:          state_d = StJump;
          default:      state_d = StFetch;
        endcase
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_src_b = AluBRt;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = AluBImm;
        ovf_d     = (op_q == OpAddi) && overflow;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_wr  = 1'b1;
        reg_dst = (op_q == OpRType);
        ovf_wr  = (op_q == OpAddi);
        state_d = StFetch;
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = AluBImm;
        state_d   = (op_q == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: state_d = StMemWb;
      StMemWb: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_wr  = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_src_b = AluBRt;
        pc_src    = PcSrcBranch;
        pc_wr     = zero;
        state_d   = StFetch;
      end
      StJump: begin
        pc_wr   = 1'b1;
        pc_src  = PcSrcJump;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  alu_dec u_alu_dec (
    .state   (state_q),
    .op_q    (op_q),
    .funct_q (funct_q),
    .aluctr  (aluctr),
    .ext_op  (ext_op)
  );

  assign ovf_val = ovf_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: table of instructions with per-cycle
// expected state and write enables, pushed into a scoreboard when driven
// and compared cycle by cycle, plus hand-written reset sequences.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, overflow;
  logic       pc_wr, ir_wr, mem_wr, mem_to_reg, reg_wr, reg_dst, alu_src_a;
  logic       ext_op, ovf_wr, ovf_val;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] aluctr;
  logic [3:0] state;

  mc_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .overflow   (overflow),
    .pc_wr      (pc_wr),
    .pc_src     (pc_src),
    .ir_wr      (ir_wr),
    .mem_wr     (mem_wr),
    .mem_to_reg (mem_to_reg),
    .reg_wr     (reg_wr),
    .reg_dst    (reg_dst),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .aluctr     (aluctr),
    .ovf_wr     (ovf_wr),
    .ovf_val    (ovf_val),
    .state      (state)
  );

  always #5 clk = ~clk;

  // en bits: {pc_wr, ir_wr, mem_wr, mem_to_reg, reg_wr, ovf_wr}
  typedef struct {
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               ovf;
    int                 cpi;
    logic [0:4][3:0]    st;
    logic [0:4][5:0]    en;
    logic               alu_chk;  // check aluctr in cycle 2
    logic [2:0]         alu;
    logic [1:0]         pcs;      // pc_src whenever pc_wr after FETCH
    logic               dst;      // reg_dst whenever reg_wr
    logic               ovfv;     // ovf_val whenever ovf_wr
  } vec_t;

  typedef struct {
    logic [3:0] st;
    logic [5:0] en;
    logic       alu_chk;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic       dst;
    logic       ovfv;
  } exp_t;

  localparam int NVec = 13;
  vec_t vecs [NVec];
  exp_t sb [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Call just after a rising edge with the DUT in FETCH.
  task automatic run_vec(input int i);
    vec_t v;
    exp_t e;
    string pfx;
    v = vecs[i];
    op = v.op;
    funct = v.funct;
    zero = v.zero;
    overflow = v.ovf;
    for (int c = 0; c < v.cpi; c++) begin
      e.st      = v.st[c];
      e.en      = v.en[c];
      e.alu_chk = (c < 2) || (c == 2 && v.alu_chk);
      e.alu     = (c < 2) ? 3'b000 : v.alu;
      e.pcs     = (c == 0) ? 2'b00 : v.pcs;
      e.dst     = v.dst;
      e.ovfv    = v.ovfv;
      sb.push_back(e);
    end
    for (int c = 0; c < v.cpi; c++) begin
      @(negedge clk);
      e = sb.pop_front();
      pfx = $sformatf("v%0d c%0d", i, c);
      check({pfx, " state"}, {4'd0, state}, {4'd0, e.st});
      check({pfx, " enables"}, {2'd0, pc_wr, ir_wr, mem_wr, mem_to_reg, reg_wr, ovf_wr},
            {2'd0, e.en});
      if (e.alu_chk) check({pfx, " aluctr"}, {5'd0, aluctr}, {5'd0, e.alu});
      if (e.en[5]) check({pfx, " pc_src"}, {6'd0, pc_src}, {6'd0, e.pcs});
      if (e.en[1]) check({pfx, " reg_dst"}, {7'd0, reg_dst}, {7'd0, e.dst});
      if (e.en[0]) check({pfx, " ovf_val"}, {7'd0, ovf_val}, {7'd0, e.ovfv});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    //           op         funct      z     ov    cpi  states                          enables
    vecs[0]  = '{6'b000000, 6'b100001, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd10, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b000010, 6'b0}, 1'b1, 3'b000, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{6'b000000, 6'b100011, 1'b1, 1'b0, 4, {4'd0, 4'd1, 4'd2, 4'd10, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b000010, 6'b0}, 1'b1, 3'b001, 2'b00, 1'b1, 1'b0};
    vecs[2]  = '{6'b000000, 6'b101010, 1'b0, 1'b1, 4, {4'd0, 4'd1, 4'd2, 4'd10, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b000010, 6'b0}, 1'b1, 3'b011, 2'b00, 1'b1, 1'b0};
    vecs[3]  = '{6'b001000, 6'b000000, 1'b0, 1'b1, 4, {4'd0, 4'd1, 4'd3, 4'd10, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b000011, 6'b0}, 1'b1, 3'b100, 2'b00, 1'b0, 1'b1};
    vecs[4]  = '{6'b001101, 6'b000000, 1'b0, 1'b1, 4, {4'd0, 4'd1, 4'd3, 4'd10, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b000010, 6'b0}, 1'b1, 3'b010, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{6'b001000, 6'b111111, 1'b1, 1'b0, 4, {4'd0, 4'd1, 4'd3, 4'd10, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b000011, 6'b0}, 1'b1, 3'b100, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{6'b100011, 6'b000000, 1'b0, 1'b0, 5, {4'd0, 4'd1, 4'd4, 4'd5, 4'd6},
                 {6'b110000, 6'b0, 6'b0, 6'b0, 6'b000110}, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{6'b101011, 6'b000000, 1'b0, 1'b0, 4, {4'd0, 4'd1, 4'd4, 4'd7, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b001000, 6'b0}, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{6'b000100, 6'b000000, 1'b1, 1'b0, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},
                 {6'b110000, 6'b0, 6'b100000, 6'b0, 6'b0}, 1'b1, 3'b001, 2'b01, 1'b0, 1'b0};
    vecs[9]  = '{6'b000100, 6'b000000, 1'b0, 1'b0, 3, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b0, 6'b0}, 1'b1, 3'b001, 2'b01, 1'b0, 1'b0};
    vecs[10] = '{6'b000010, 6'b000000, 1'b0, 1'b0, 3, {4'd0, 4'd1, 4'd9, 4'd0, 4'd0},
                 {6'b110000, 6'b0, 6'b100000, 6'b0, 6'b0}, 1'b0, 3'b000, 2'b10, 1'b0, 1'b0};
    vecs[11] = '{6'b111111, 6'b100001, 1'b0, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b0, 6'b0}, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};
    vecs[12] = '{6'b000000, 6'b000000, 1'b0, 1'b0, 2, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0},
                 {6'b110000, 6'b0, 6'b0, 6'b0, 6'b0}, 1'b0, 3'b000, 2'b00, 1'b0, 1'b0};

    rst_n = 1'b0;
    op = 6'd0;
    funct = 6'd0;
    zero = 1'b0;
    overflow = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset state", {4'd0, state}, 8'd0);
    check("reset reg_wr", {7'd0, reg_wr}, 8'd0);
    check("reset ovf_val", {7'd0, ovf_val}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) run_vec(i);

    // lw abandoned by reset during MEMRD
    op = 6'b100011;
    funct = 6'd0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("pre-reset state MEMRD", {4'd0, state}, 8'd5);
    rst_n = 1'b0;
    #1;
    check("async reset state", {4'd0, state}, 8'd0);
    check("async reset reg_wr", {7'd0, reg_wr}, 8'd0);
    @(posedge clk);
    #1;
    check("held reset state", {4'd0, state}, 8'd0);
    check("held reset reg_wr", {7'd0, reg_wr}, 8'd0);
    check("held reset mem_to_reg", {7'd0, mem_to_reg}, 8'd0);
    rst_n = 1'b1;
    run_vec(0);

    check("scoreboard drained", 8'(sb.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
